// File: rtl/bus_mux_arb.sv
// N-input registered bus mux with round-robin arbitration and a single backpressured output stage.
// Define BUS_MUX_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module bus_mux_arb #(
  parameter int WIDTH = 64,
  parameter int NUM_IN = 4,
  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  logic [WIDTH-1:0]  chan_data [NUM_IN];
  logic [WIDTH-1:0]  out_data_reg;
  logic              out_valid_reg;
  logic [SEL_W-1:0]  out_sel_reg;
  logic              load_en;
  logic              grant_any;
  logic [SEL_W-1:0]  grant_idx;
  logic [NUM_IN-1:0] grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign grant[gi]     = grant_any && (grant_idx == SEL_W'(gi));
      // Reset gates ready so no source believes a beat was taken while state is being cleared.
      assign in_ready[gi]  = !reset && load_en && grant[gi];
    end
  endgenerate

  assign load_en = !out_valid_reg || out_ready;

`ifdef BUS_MUX_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    // Descending scan so the lowest-index requester is the last (winning) assignment.
    for (int c = NUM_IN - 1; c >= 0; c--) begin
      if (in_valid[c]) begin
        grant_any = 1'b1;
        grant_idx = SEL_W'(c);
      end
    end
  end
`else
  logic [SEL_W-1:0] last_grant_reg;
  logic [5:0]       cand;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    // Search starts just after the previous winner and wraps, giving round-robin order.
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = 6'(last_grant_reg) + 6'(k);
      if (cand >= 6'(NUM_IN)) begin
        cand = cand - 6'(NUM_IN);
      end
      if (!grant_any && in_valid[cand[SEL_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= SEL_W'(NUM_IN - 1);
    end else if (load_en && grant_any) begin
      last_grant_reg <= grant_idx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else if (load_en) begin
      if (grant_any) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= chan_data[grant_idx];
        out_sel_reg   <= grant_idx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_sel   = out_sel_reg;

endmodule
